// File: rtl/cc_in_collect.sv
// Collects a 4-beat burst of signed samples for a combinational compute stage.
// It registers the compute result and strobes it out; a burst that stalls too long is aborted.
module cc_in_collect #(
  parameter int GAP_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic signed [3:0] in_data,
  input  logic        [3:0] in_opt,
  output logic              in_ready,
  output logic signed [3:0] cc_in_n0,
  output logic signed [3:0] cc_in_n1,
  output logic signed [3:0] cc_in_n2,
  output logic signed [3:0] cc_in_n3,
  output logic        [3:0] cc_opt,
  input  logic signed [8:0] cc_out_n,
  output logic              out_valid,
  output logic signed [8:0] out_data,
  output logic              abort
);

  typedef enum logic [1:0] {IDLE, COLLECT, CALC, OUT} state_t;

  state_t     state, state_nxt;
  logic [1:0] cnt;
  logic [7:0] gap;
  logic       accept;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = COLLECT;
      end
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (cnt == 2'd3) state_nxt = CALC;
        end else if (gap == 8'(GAP_MAX - 1)) begin
          // This idle cycle is the GAP_MAX-th in a row; a beat here would have saved the burst.
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      CALC:    state_nxt = OUT;
      default: begin
        out_valid = 1'b1;
        state_nxt = IDLE;
      end
    endcase
    if (rst) begin
      abort     = 1'b0;
      out_valid = 1'b0;
    end
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      gap      <= 8'd0;
      cc_in_n0 <= 4'sd0;
      cc_in_n1 <= 4'sd0;
      cc_in_n2 <= 4'sd0;
      cc_in_n3 <= 4'sd0;
      cc_opt   <= 4'd0;
      out_data <= 9'sd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            cc_in_n0 <= in_data;
            cc_opt   <= in_opt;
            cnt      <= 2'd1;
            gap      <= 8'd0;
          end
        end
        COLLECT: begin
          if (accept) begin
            case (cnt)
              2'd1:    cc_in_n1 <= in_data;
              2'd2:    cc_in_n2 <= in_data;
              default: cc_in_n3 <= in_data;
            endcase
            // Leaving COLLECT from count 3 resets the count rather than wrapping it.
            cnt <= (cnt == 2'd3) ? 2'd0 : cnt + 2'd1;
            gap <= 8'd0;
          end else if (abort) begin
            cnt <= 2'd0;
            gap <= 8'd0;
          end else begin
            gap <= gap + 8'd1;
          end
        end
        CALC:    out_data <= cc_out_n;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cc_in_collect.md
CC_IN_COLLECT -- requirements
Module: cc_in_collect

Interface
REQ-001 The module SHALL have parameter GAP_MAX, default 8, giving the maximum number of consecutive idle cycles allowed between beats of one burst before the burst is aborted (legal range 1..255).
REQ-002 The clock and reset SHALL be: clk  input  1  single clock, all state on rising edge.
REQ-003 The reset SHALL be: rst  input  1  synchronous, active-high reset.
REQ-004 The input beat valid SHALL be: in_valid  input  1  a beat is offered this cycle.
REQ-005 The input data SHALL be: in_data  input  4  signed sample, one per beat.
REQ-006 The input option SHALL be: in_opt  input  4  option word, sampled on beat 0 only.
REQ-007 The ready output SHALL be: in_ready  output  1  the block accepts a beat this cycle.
REQ-008 The compute-stage samples SHALL be: cc_in_n0..cc_in_n3  output  4 each  signed samples to the combinational compute stage.
REQ-009 The compute-stage option SHALL be: cc_opt  output  4  option to the compute stage.
REQ-010 The compute-stage result SHALL be: cc_out_n  input  9  signed result from the compute stage.
REQ-011 The result valid SHALL be: out_valid  output  1  single-cycle result strobe.
REQ-012 The result data SHALL be: out_data  output  9  signed registered result.
REQ-013 The abort flag SHALL be: abort  output  1  single-cycle pulse when a burst times out.

Function
REQ-014 The block SHALL implement the states IDLE, COLLECT, CALC and OUT.
REQ-015 A beat SHALL be accepted when in_valid and in_ready are both 1; in_ready SHALL be 1 only in IDLE and COLLECT.
REQ-016 In IDLE, an accepted beat SHALL store in_data into slot 0, latch in_opt into cc_opt, set the beat count to 1 and move to COLLECT.
REQ-017 In COLLECT, an accepted beat SHALL store in_data into the slot given by the beat count (1, 2, 3 in that order); after slot 3 is stored the next state SHALL be CALC.
REQ-018 In COLLECT, in_opt SHALL be ignored.
REQ-019 Slots 0..3 SHALL drive cc_in_n0..cc_in_n3 directly from registers, and those registers SHALL stay stable from CALC through OUT.
REQ-020 In CALC, which lasts exactly one cycle, cc_out_n SHALL be registered into out_data and the next state SHALL be OUT.
REQ-021 In OUT, which lasts exactly one cycle, out_valid SHALL be 1 and the next state SHALL be IDLE.
REQ-022 Latency SHALL be 2 cycles from the cycle that accepts beat 3 to the out_valid cycle.
REQ-023 Minimum burst spacing SHALL be 6 cycles from beat 0 to the next beat 0 (4 beats, CALC, OUT).
REQ-024 out_data SHALL hold its value until the next CALC; a 9-bit value SHALL be stored with no extension or truncation.
REQ-025 Gap counter: in COLLECT, each cycle without in_valid SHALL increment the gap counter, and an accepted beat SHALL clear it to 0.
REQ-026 When the gap counter reaches GAP_MAX, the block SHALL pulse abort for 1 cycle, return to IDLE and clear the beat count; cc_in_n*, cc_opt and out_data SHALL be left unchanged; out_valid SHALL NOT be asserted.
REQ-027 If in_valid is 1 in the cycle the gap counter would reach GAP_MAX, the beat SHALL be accepted and no abort SHALL occur.
REQ-028 in_valid during CALC or OUT SHALL be ignored, since in_ready is 0 in those states.
REQ-029 The beat count SHALL be 2 bits; it SHALL never wrap within a burst because the exit from COLLECT is taken at count 3.
REQ-030 A beat offered in the same cycle as out_valid SHALL NOT be accepted; a beat in the cycle after OUT SHALL be accepted.

Reset
REQ-031 When rst=1 at a clk edge, the block SHALL enter IDLE.
REQ-032 When rst=1 at a clk edge, the beat count and gap counter SHALL be cleared to 0.
REQ-033 When rst=1 at a clk edge, cc_in_n0..cc_in_n3 SHALL be 0, cc_opt SHALL be 0 and out_data SHALL be 0.
REQ-034 When rst=1 at a clk edge, out_valid SHALL be 0 and abort SHALL be 0.
REQ-035 When rst=1 at a clk edge, in_ready SHALL be 1 in the first cycle after rst is released.
REQ-036 Reset SHALL override every other event, including an in-flight burst, CALC or OUT; no out_valid or abort SHALL follow.

Verification
REQ-037 Back-to-back bursts: beats 3,-2,7,0 with in_opt=4'b0000, compute stage returns 9'sd-21 -> out_valid exactly 2 cycles after beat 3, out_data=-21, in_ready=0 for exactly 2 cycles.
REQ-038 Gapped burst: beats with 2 idle cycles between each, GAP_MAX=8 -> no abort; out_valid once; cc_opt equals the beat-0 in_opt, not the in_opt values on later beats.
REQ-039 Timeout: 2 beats, then in_valid=0 for 8 cycles -> abort pulses once on the 8th idle cycle; no out_valid; the next beat is treated as beat 0.
REQ-040 Boundary gap: 7 idle cycles, then in_valid on the 8th cycle -> beat accepted, no abort.
REQ-041 Reset mid-burst: after 3 beats, assert rst for 1 cycle -> all outputs are 0, in_ready=1; a fresh 4-beat burst completes normally.
REQ-042 Extremes: beats -8,-8,-8,-8 with in_opt=4'b1111, compute result -256 -> out_data=9'h100 held stable until the next CALC; in_valid held high during CALC/OUT has no effect.
